// File: rtl/ucaspian_packet_encoder_pkg.sv
// Shared opcodes, packet lengths, source/state enums and the packet builder
// for the uCaspian host-bound packet encoder.
package ucaspian_pkt_pkg;

    localparam logic [7:0] OP_FIRE      = 8'h41;
    localparam logic [7:0] OP_TIME      = 8'h42;
    localparam logic [7:0] OP_METRIC    = 8'h43;
    localparam logic [7:0] OP_CLEAR_ACK = 8'h44;
    localparam logic [7:0] OP_CFG_ACK   = 8'h45;

    localparam logic [2:0] LEN_FIRE      = 3'd2;
    localparam logic [2:0] LEN_TIME      = 3'd5;
    localparam logic [2:0] LEN_METRIC    = 3'd2;
    localparam logic [2:0] LEN_CLEAR_ACK = 3'd1;
    localparam logic [2:0] LEN_CFG_ACK   = 3'd1;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_CLEAR,
        SRC_METRIC,
        SRC_TIME,
        SRC_FIRE,
        SRC_CFG
    } src_e;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    // First byte on the wire sits in data[39:32].
    typedef struct packed {
        logic [39:0] data;
        logic [2:0]  len;
    } pkt_t;

    function automatic pkt_t build_pkt(input src_e       src,
                                       input logic [7:0]  addr,
                                       input logic [31:0] tval,
                                       input logic [7:0]  mval);
        pkt_t p;
        p = '0;
        case (src)
            SRC_CLEAR: begin
                p.data = {OP_CLEAR_ACK, 32'h0};
                p.len  = LEN_CLEAR_ACK;
            end
            SRC_METRIC: begin
                p.data = {OP_METRIC, mval, 24'h0};
                p.len  = LEN_METRIC;
            end
            SRC_TIME: begin
                p.data = {OP_TIME, tval};
                p.len  = LEN_TIME;
            end
            SRC_FIRE: begin
                p.data = {OP_FIRE, addr, 24'h0};
                p.len  = LEN_FIRE;
            end
            SRC_CFG: begin
                p.data = {OP_CFG_ACK, 32'h0};
                p.len  = LEN_CFG_ACK;
            end
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ucaspian_packet_encoder_if.sv
// Valid/ready byte stream from the packet encoder to the UART/USB transmitter.
interface ucaspian_packet_encoder_if;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_rdy;

    modport master (output tx_data, output tx_vld, input tx_rdy);
    modport slave  (input tx_data, input tx_vld, output tx_rdy);
endinterface

// File: rtl/ucaspian_packet_encoder_serializer.sv
// Byte serializer: shifts a loaded packet out MSB-first on a valid/ready stream.
module ucaspian_byte_serializer
    import ucaspian_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  pkt_t       i_pkt,
    input  logic       i_tx_rdy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_vld,
    output logic       o_last_xfer
);

    logic [39:0] r_shift;
    logic [2:0]  r_cnt;
    logic        w_xfer;

    // Valid is derived from the remaining-byte count so it can only fall on a handshake.
    assign o_tx_vld    = (r_cnt != 3'd0);
    assign o_tx_data   = r_shift[39:32];
    assign w_xfer      = o_tx_vld && i_tx_rdy;
    assign o_last_xfer = w_xfer && (r_cnt == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_pkt.data;
            r_cnt   <= i_pkt.len;
        end else if (w_xfer) begin
            r_shift <= {r_shift[31:0], 8'h00};
            r_cnt   <= r_cnt - 3'd1;
        end
    end

endmodule

// File: rtl/ucaspian_packet_encoder.sv
// Host-bound packet encoder: arbitrates core events, builds packets and
// generates the acknowledge strobes the core waits on.
module ucaspian_packet_encoder
    import ucaspian_pkt_pkg::*;
#(
    parameter bit TIME_PKT_EN = 1'b1,
    parameter bit CFG_ACK_EN  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 output_fire_addr,
    input  logic                       output_fire_waiting,
    output logic                       output_fire_sent,
    input  logic [31:0]                time_current,
    input  logic                       time_update,
    output logic                       time_sent,
    input  logic [7:0]                 metric_value,
    input  logic                       metric_send,
    input  logic                       clear_done,
    output logic                       ack_sent,
    input  logic                       config_done,
    ucaspian_packet_encoder_if.master  tx,
    output logic                       busy
);

    state_e     r_state;
    state_e     w_next;
    src_e       w_src;
    pkt_t       w_pkt;
    logic       w_load;
    logic       w_last_xfer;

    logic       r_fire_sent, r_fire_hold;
    logic       r_time_sent, r_time_hold;
    logic       r_ack_hold;
    logic       r_clear_inflight;
    logic       r_metric_pend;
    logic [7:0] r_metric_val;
    logic       r_cfg_pend;
    logic       r_cfg_prev;

    logic       w_clear_elig, w_metric_elig, w_time_elig, w_fire_elig, w_cfg_elig;
    logic       w_cfg_rise;
    logic [7:0] w_metric_byte;

    // Level sources stay masked during their strobe and one cycle after, giving the core time to drop them.
    assign w_clear_elig  = clear_done && !r_clear_inflight && !r_ack_hold;
    assign w_time_elig   = time_update && !r_time_sent && !r_time_hold;
    assign w_fire_elig   = output_fire_waiting && !r_fire_sent && !r_fire_hold;
    assign w_metric_elig = r_metric_pend || metric_send;
    assign w_metric_byte = metric_send ? metric_value : r_metric_val;
    assign w_cfg_rise    = config_done && !r_cfg_prev;
    assign w_cfg_elig    = CFG_ACK_EN && (r_cfg_pend || w_cfg_rise);

    assign output_fire_sent = r_fire_sent;
    assign time_sent        = r_time_sent;
    assign ack_sent         = w_last_xfer && r_clear_inflight;

    assign busy = (r_state != IDLE) || r_metric_pend || r_cfg_pend || w_clear_elig ||
                  w_metric_elig || w_time_elig || w_fire_elig || w_cfg_elig;

    always_comb begin
        w_src  = SRC_NONE;
        w_pkt  = '0;
        w_load = 1'b0;
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_clear_elig)       w_src = SRC_CLEAR;
                else if (w_metric_elig) w_src = SRC_METRIC;
                else if (w_time_elig)   w_src = SRC_TIME;
                else if (w_fire_elig)   w_src = SRC_FIRE;
                else if (w_cfg_elig)    w_src = SRC_CFG;
                w_pkt  = build_pkt(w_src, output_fire_addr, time_current, w_metric_byte);
                // A silent time capture still strobes time_sent but loads nothing.
                w_load = (w_src != SRC_NONE) && !((w_src == SRC_TIME) && !TIME_PKT_EN);
                if (w_load) w_next = SEND;
            end
            SEND: begin
                if (w_last_xfer) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fire_sent      <= 1'b0;
            r_fire_hold      <= 1'b0;
            r_time_sent      <= 1'b0;
            r_time_hold      <= 1'b0;
            r_ack_hold       <= 1'b0;
            r_clear_inflight <= 1'b0;
            r_metric_pend    <= 1'b0;
            r_metric_val     <= '0;
            r_cfg_pend       <= 1'b0;
            r_cfg_prev       <= 1'b0;
        end else begin
            r_fire_sent <= (w_src == SRC_FIRE);
            r_fire_hold <= r_fire_sent;
            r_time_sent <= (w_src == SRC_TIME);
            r_time_hold <= r_time_sent;
            r_ack_hold  <= ack_sent;

            if (w_src == SRC_CLEAR)  r_clear_inflight <= 1'b1;
            else if (w_last_xfer)    r_clear_inflight <= 1'b0;

            // A metric arriving while another source wins arbitration is parked here.
            if (w_src == SRC_METRIC) begin
                r_metric_pend <= 1'b0;
            end else if (metric_send) begin
                r_metric_pend <= 1'b1;
                r_metric_val  <= metric_value;
            end

            r_cfg_prev <= config_done;
            if (w_src == SRC_CFG)                 r_cfg_pend <= 1'b0;
            else if (w_cfg_rise && CFG_ACK_EN)    r_cfg_pend <= 1'b1;
        end
    end

    ucaspian_byte_serializer u_ser (
        .clk         (clk),
        .rst_n       (reset),
        .i_load      (w_load),
        .i_pkt       (w_pkt),
        .i_tx_rdy    (tx.tx_rdy),
        .o_tx_data   (tx.tx_data),
        .o_tx_vld    (tx.tx_vld),
        .o_last_xfer (w_last_xfer)
    );

endmodule

// File: tb/tb_ucaspian_packet_encoder.sv
// Scoreboard bench for ucaspian_packet_encoder: expected packets are queued from a
// priority-order event model and popped by a monitor on every accepted byte.
module tb_ucaspian_packet_encoder;
    import ucaspian_pkt_pkg::*;

    typedef struct {
        logic [7:0] b;
        logic       ack;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  fire_addr;
    logic        fire_wait;
    logic        fire_sent;
    logic [31:0] time_cur;
    logic        time_upd;
    logic        time_snt;
    logic [7:0]  metric_val;
    logic        metric_send;
    logic        clear_done;
    logic        ack_sent;
    logic        config_done;
    logic        busy;

    logic        time2_upd;
    logic        cfg2;
    logic        fire_sent2, time_sent2, ack_sent2, busy2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_bytes  = 0;
    int          n_fire   = 0;
    int          n_time   = 0;
    int          n_ack    = 0;
    int          n_time2  = 0;
    int          n_vld2   = 0;
    int          rdy_mode = 0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    ucaspian_packet_encoder_if tx_if ();
    ucaspian_packet_encoder_if tx2_if ();

    ucaspian_packet_encoder #(.TIME_PKT_EN(1'b1), .CFG_ACK_EN(1'b1)) dut (
        .clk                 (clk),
        .reset               (rst_n),
        .output_fire_addr    (fire_addr),
        .output_fire_waiting (fire_wait),
        .output_fire_sent    (fire_sent),
        .time_current        (time_cur),
        .time_update         (time_upd),
        .time_sent           (time_snt),
        .metric_value        (metric_val),
        .metric_send         (metric_send),
        .clear_done          (clear_done),
        .ack_sent            (ack_sent),
        .config_done         (config_done),
        .tx                  (tx_if.master),
        .busy                (busy)
    );

    ucaspian_packet_encoder #(.TIME_PKT_EN(1'b0), .CFG_ACK_EN(1'b0)) dut2 (
        .clk                 (clk),
        .reset               (rst_n),
        .output_fire_addr    (8'h00),
        .output_fire_waiting (1'b0),
        .output_fire_sent    (fire_sent2),
        .time_current        (32'hDEADBEEF),
        .time_update         (time2_upd),
        .time_sent           (time_sent2),
        .metric_value        (8'h00),
        .metric_send         (1'b0),
        .clear_done          (1'b0),
        .ack_sent            (ack_sent2),
        .config_done         (cfg2),
        .tx                  (tx2_if.master),
        .busy                (busy2)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic a);
        exp_t e;
        e.b   = b;
        e.ack = a;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every accepted byte and hold stability across stalls.
    initial begin : monitor
        logic       stall;
        logic [7:0] stall_data;
        exp_t       e;
        stall      = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("stall_vld", tx_if.tx_vld, 1'b1);
                    check("stall_data", tx_if.tx_data, stall_data);
                end
                if (tx_if.tx_vld && tx_if.tx_rdy) begin
                    n_bytes++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_byte: got %02h expected none at %0t", tx_if.tx_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", tx_if.tx_data, e.b);
                        check("ack_sent", ack_sent, e.ack);
                    end
                end else begin
                    if (ack_sent) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL ack_sent: got 1 expected 0 outside transfer at %0t", $time);
                    end
                end
                stall      = tx_if.tx_vld && !tx_if.tx_rdy;
                stall_data = tx_if.tx_data;
            end
        end
    end

    // Core model: drop each level source once its strobe is seen.
    initial begin : core_model
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fire_sent)  begin fire_wait  = 1'b0; n_fire++; end
                if (time_snt)   begin time_upd   = 1'b0; n_time++; end
                if (ack_sent)   begin clear_done = 1'b0; n_ack++;  end
                if (time_sent2) begin time2_upd  = 1'b0; n_time2++; end
                if (tx2_if.tx_vld) n_vld2++;
            end
        end
    end

    initial begin : rdy_drive
        tx_if.tx_rdy  = 1'b1;
        tx2_if.tx_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_if.tx_rdy = 1'b1;
                1:       tx_if.tx_rdy = ~tx_if.tx_rdy;
                default: tx_if.tx_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // mask bits: [4] clear, [3] metric, [2] time, [1] fire, [0] cfg
    task automatic run_round(input logic [4:0] mask, input logic [7:0] addr, input logic [31:0] tval,
                             input logic [7:0] mval, input int cfg_hold);
        int  f0, t0, a0;
        bit  done;
        f0 = n_fire;
        t0 = n_time;
        a0 = n_ack;
        @(posedge clk);
        #1;
        if (mask[4]) push(OP_CLEAR_ACK, 1'b1);
        if (mask[3]) begin push(OP_METRIC, 1'b0); push(mval, 1'b0); end
        if (mask[2]) begin
            push(OP_TIME, 1'b0);
            for (int i = 3; i >= 0; i--) push(tval[8*i +: 8], 1'b0);
        end
        if (mask[1]) begin push(OP_FIRE, 1'b0); push(addr, 1'b0); end
        if (mask[0]) push(OP_CFG_ACK, 1'b0);
        fire_addr   = addr;
        time_cur    = tval;
        metric_val  = mval;
        clear_done  = mask[4];
        metric_send = mask[3];
        time_upd    = mask[2];
        fire_wait   = mask[1];
        config_done = mask[0];
        done = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            metric_send = 1'b0;
            if (c + 1 >= cfg_hold) config_done = 1'b0;
            if (c >= cfg_hold && exp_q.size() == 0 && !busy && !tx_if.tx_vld) begin
                done = 1'b1;
                break;
            end
        end
        check("round_done", done, 1'b1);
        check("q_empty", exp_q.size(), 0);
        check("fire_pulses", n_fire - f0, int'(mask[1]));
        check("time_pulses", n_time - t0, int'(mask[2]));
        check("ack_pulses", n_ack - a0, int'(mask[4]));
        exp_q.delete();
        fire_wait   = 1'b0;
        time_upd    = 1'b0;
        clear_done  = 1'b0;
        config_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int  b0, t0;
        bit  hit;
        rst_n       = 1'b0;
        fire_addr   = '0;
        fire_wait   = 1'b0;
        time_cur    = '0;
        time_upd    = 1'b0;
        metric_val  = '0;
        metric_send = 1'b0;
        clear_done  = 1'b0;
        config_done = 1'b0;
        time2_upd   = 1'b0;
        cfg2        = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", tx_if.tx_vld, 1'b0);
        check("rst_data", tx_if.tx_data, 8'h00);
        check("rst_strobes", {fire_sent, time_snt, ack_sent}, 3'b000);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        rdy_mode = 0; run_round(5'b00010, 8'h2A, 32'h0, 8'h0, 0);
        rdy_mode = 1; run_round(5'b00100, 8'h00, 32'h01020304, 8'h0, 0);
        rdy_mode = 0; run_round(5'b11110, 8'h05, 32'hA1B2C3D4, 8'h07, 0);
        rdy_mode = 0; run_round(5'b00001, 8'h00, 32'h0, 8'h0, 3);

        for (int r = 0; r < 30; r++) begin
            rdy_mode = $urandom_range(0, 2);
            run_round(5'($urandom_range(1, 31)), 8'($urandom), $urandom, 8'($urandom),
                      $urandom_range(1, 4));
        end

        // Abandon a TIME packet after two bytes.
        rdy_mode = 0;
        b0 = n_bytes;
        t0 = n_time;
        @(posedge clk);
        #1;
        push(OP_TIME, 1'b0);
        push(8'h0A, 1'b0); push(8'h0B, 1'b0); push(8'h0C, 1'b0); push(8'h0D, 1'b0);
        time_cur = 32'h0A0B0C0D;
        time_upd = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (n_bytes >= b0 + 2) begin hit = 1'b1; break; end
        end
        check("reset_reach_byte2", hit, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        time_upd = 1'b0;
        #1;
        check("midrst_vld", tx_if.tx_vld, 1'b0);
        check("midrst_strobes", {fire_sent, time_snt, ack_sent}, 3'b000);
        check("midrst_time_pulses", n_time - t0, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        b0 = n_bytes;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_bytes", n_bytes - b0, 0);
        check("post_reset_busy", busy, 1'b0);

        // Variant with silent time and no config acks.
        t0 = n_time2;
        time2_upd = 1'b1;
        cfg2      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cfg2 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("silent_time_pulses", n_time2 - t0, 1);
        check("silent_no_vld", n_vld2, 0);
        check("silent_busy", busy2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ucaspian_packet_encoder.md
Name: ucaspian_packet_encoder

Overview:
Host-bound half of the uCaspian I/O path. Consumes the core's outbound event interfaces (output fires, time updates, metric replies, clear and config acknowledgements), arbitrates among them, and serializes each into a byte packet on a valid/ready byte stream toward the UART/USB transmitter. It generates the acknowledge strobes the core waits on (output_fire_sent, time_sent, ack_sent).

Parameters:
TIME_PKT_EN, 1, 1 = time_update emits a TIME packet; 0 = time_update is acknowledged silently with no packet.
CFG_ACK_EN, 1, 1 = each config_done rising edge emits a CFG_ACK packet; 0 = ignored.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
output_fire_addr  in  8  neuron address of pending output fire
output_fire_waiting  in  1  output fire pending (level, held until sent)
output_fire_sent  out  1  one-cycle ack: fire captured
time_current  in  32  core time
time_update  in  1  time advanced (level, held until sent)
time_sent  out  1  one-cycle ack: time captured
metric_value  in  8  metric reply byte
metric_send  in  1  metric reply valid (sample on any high cycle)
clear_done  in  1  clear complete (level, held until ack_sent)
ack_sent  out  1  one-cycle ack: clear-ack packet fully transmitted
config_done  in  1  config write complete (level; rising edge is the event)
tx_data  out  8  packet byte
tx_vld  out  1  tx_data valid
tx_rdy  in  1  downstream accepts byte
busy  out  1  packet in flight or any event pending

Behaviour:
- Opcodes (package constants): OP_FIRE=8'h41 + addr (2 B); OP_TIME=8'h42 + time[31:24],[23:16],[15:8],[7:0] (5 B, MSB first); OP_METRIC=8'h43 + value (2 B); OP_CLEAR_ACK=8'h44 (1 B); OP_CFG_ACK=8'h45 (1 B).
- Reset (reset low, async): all outputs 0, FSM IDLE, pending flags cleared, byte counter 0.
- Pending capture: metric_send high sets metric_pend and latches metric_value (a later metric_send while pending overwrites the value, no second packet). config_done 0->1 edge sets cfg_pend (edge detector reset to 0). Level sources (fire, time, clear) are not latched; they are sampled at arbitration.
- FSM IDLE: each cycle, choose the highest-priority eligible source: clear > metric > time > fire > cfg. Load a 5-byte shift register and length (1-5); go to SEND. Capturing fire pulses output_fire_sent; capturing time pulses time_sent and snapshots time_current. Strobes are registered, one cycle wide.
- Eligibility: a level source is ineligible in the cycle its own ack strobe is high and the cycle after, so the core has time to drop the level (no double capture). Clear is ineligible while clear packet in flight or ack_sent high.
- SEND: tx_vld=1, tx_data=current byte, held stable until tx_rdy. On tx_vld&&tx_rdy, advance. After the last byte, return to IDLE; if the packet was CLEAR_ACK, pulse ack_sent in that same transfer cycle. Back-to-back packets are allowed: IDLE arbitration takes 1 cycle, so there is a minimum of one bubble between packets.
- tx_vld is never deasserted before handshake. Byte order and packet contents are frozen at capture.
- TIME_PKT_EN=0: time still captured (time_sent pulses), no bytes emitted, FSM stays IDLE.
- busy = (state!=IDLE) || any pending or eligible source.
- Simultaneous events: all pending ones are served in priority order over successive packets; none is lost. Fire and time ordering is preserved because the core advances time only after output_fire_waiting clears.
- Reset mid-packet: the packet is abandoned, no further bytes are sent, and pending flags are lost.

Decomposition:
- Package ucaspian_pkt_pkg: opcode localparams, packet length constants, the source enum (SRC_CLEAR, SRC_METRIC, SRC_TIME, SRC_FIRE, SRC_CFG), and the FSM state enum (IDLE, SEND).
- Sub-module ucaspian_byte_serializer: 5-byte shift register, length counter and valid/ready output stage. The top level holds arbitration, pending flags and ack generation.

Test Plan:
- Fire only: addr=0x2A, waiting high, tx_rdy=1 -> output_fire_sent single pulse; bytes 41,2A; no second packet while waiting falls.
- Time with backpressure: time_current=0x01020304, update high, tx_rdy toggling 1/0 -> bytes 42,01,02,03,04; tx_data stable during stall; time_sent single pulse.
- Simultaneous: clear_done, metric_send(val 0x07), time_update, fire(0x05) in the same cycle -> packets 44 | 43,07 | 42,… | 41,05 in that order; ack_sent pulses on the transfer of byte 44.
- Config edge: config_done held high 3 cycles -> exactly one byte 45; CFG_ACK_EN=0 -> none.
- Reset mid-packet: assert reset low after byte 2 of a TIME packet -> tx_vld=0 immediately, all strobes 0; after release, the idle stream is empty.
- TIME_PKT_EN=0: time_update -> time_sent pulse, no tx_vld.
